run_watchdog: RTL
=================

// Module: run_watchdog
// PURPOSE
//  Synthesizable, parametrised run monitor for the three-stage RISC-V pipeline.
//  Sits beside the core and watches the fetch PC, the exception flag and NCH memory address channels.
//  Detects a PC hang (timeout), an out-of-range access or an exception; latches the first cause and
//  fault address, drains for a fixed number of cycles, then raises a sticky halt.
// PARAMETERS
//  NCH          2                   number of monitored address channels (ch0 = imem, ch1 = dmem write)
//  AW           32                  address width of pc and channel addresses
//  CH_LIMIT_LOG2 {8'd18,8'd17}      packed 8 bits per channel, ch i at [8i+7:8i]; legal iff addr < 2**value
//  TIMEOUT      100                 consecutive unchanged-PC cycles that trigger a hang fault (>=1)
//  DRAIN_CYCLES 1                   cycles spent in DRAIN between trigger and halt (0 = direct)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  reset        in   1        asynchronous, active-low reset
//  stall        in   1        1 = core held; monitor idles
//  clear        in   1        synchronous restart from DONE
//  exception    in   1        core exception flag
//  pc           in   AW       current fetch PC
//  ch_valid     in   NCH      per-channel access strobe
//  ch_addr      in   NCH*AW   per-channel byte address, ch i at [AW*i+AW-1:AW*i]
//  running      out  1        state == RUN
//  halt         out  1        state == DONE (level)
//  halt_pulse   out  1        one-cycle pulse on entry to DONE
//  cause        out  2        0 none, 1 exception, 2 range, 3 timeout
//  fault_ch     out  max(1,$clog2(NCH))  channel of range fault, else 0
//  fault_addr   out  AW       offending address (range) or pc (exception/timeout)
//  cycle_cnt    out  32       cycles spent in RUN, frozen at trigger
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; pc_q=0, hang counter=0, drain counter=0.
//  States: IDLE, RUN, DRAIN, DONE (2-bit encoding).
//  IDLE: -> RUN when stall==0. Hang counter held at 0. cause/fault/cycle_cnt retained.
//  RUN: cycle_cnt += 1 per cycle (wraps at 2**32); pc_q <= pc every cycle.
//   hang counter (width $clog2(TIMEOUT+1)): pc==pc_q -> +1 saturating at TIMEOUT; else -> 0.
//   stall==1 -> IDLE, hang counter cleared, no trigger evaluated that cycle.
//  Triggers (RUN only, evaluated on registered state, same cycle priority high->low):
//   1 exception==1                            -> cause=1, fault_addr=pc
//   2 any i: ch_valid[i] && ch_addr_i[AW-1:CH_LIMIT_LOG2_i]!=0 -> cause=2,
//     lowest such i in fault_ch, fault_addr=ch_addr_i; CH_LIMIT_LOG2_i>=AW means never faults
//   3 hang counter == TIMEOUT                 -> cause=3, fault_addr=pc_q
//   On trigger: latch cause/fault_ch/fault_addr, freeze cycle_cnt (triggering cycle not counted),
//   go DRAIN (drain counter=DRAIN_CYCLES) or DONE directly if DRAIN_CYCLES==0.
//  DRAIN: decrement drain counter; -> DONE when it reaches 1 (exactly DRAIN_CYCLES cycles in DRAIN).
//   Further triggers, stall and clear ignored; first cause is sticky.
//  DONE: halt=1; halt_pulse=1 only on first DONE cycle. clear==1 -> IDLE next cycle with cause,
//   fault_ch, fault_addr, cycle_cnt, hang counter cleared. clear ignored in IDLE/RUN/DRAIN.
//  Latency: trigger sampled at edge N -> DRAIN at N; halt rises at edge N+DRAIN_CYCLES.
//  Reset asserted in any state aborts immediately to IDLE with all outputs 0.
// TESTING
//  T1 reset low 10 cycles, stall=1 10 cycles, then stall=0 with pc incrementing by 4 -> running=1,
//     cause=0, cycle_cnt tracks cycles, halt stays 0 for 1000 cycles.
//  T2 pc frozen at 0x40 in RUN -> hang counter reaches 100, cause=3, fault_addr=0x40, halt 1+DRAIN
//     cycles later, halt_pulse exactly 1 cycle wide.
//  T3 ch_valid=2'b11, ch0 addr 0x0002_0000, ch1 addr 0x0004_0000 same cycle -> cause=2, fault_ch=0,
//     fault_addr=0x0002_0000; ch1 addr 0x0001_FFFC alone -> no fault.
//  T4 exception=1 together with ch0 out of range and hang at TIMEOUT -> cause=1, fault_addr=pc;
//     second exception during DRAIN leaves cause/fault_addr unchanged.
//  T5 in DONE assert clear 1 cycle -> IDLE, all status 0, rerun with stall=0 re-enters RUN;
//     clear pulsed in RUN has no effect.
//  T6 reset dropped during DRAIN and during RUN -> outputs 0 immediately (async), state IDLE;
//     stall=1 mid-RUN with pc frozen 99 cycles -> no timeout, counter restarts on resume.

Source files
------------

// File: rtl/run_watchdog_if.sv
// ---------------------------------------------------------------------------
// run_watchdog_if
//   Bundle of the core-side signals observed by the run watchdog.
//   master : driven by the core (or a test harness)
//   slave  : observed by run_watchdog
// Signals
//   exception  core exception flag
//   pc         current fetch PC
//   ch_valid   per-channel access strobe
//   ch_addr    per-channel byte address, channel i at [AW*i +: AW]
// ---------------------------------------------------------------------------
interface run_watchdog_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32
);
  logic              exception;
  logic [AW-1:0]     pc;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*AW-1:0] ch_addr;

  modport master (output exception, pc, ch_valid, ch_addr);
  modport slave  (input  exception, pc, ch_valid, ch_addr);
endinterface

// File: rtl/run_watchdog.sv
// ---------------------------------------------------------------------------
// run_watchdog
//   Run monitor for the three-stage RISC-V pipeline. While running it watches
//   the fetch PC for a hang, the exception flag, and NCH address channels for
//   out-of-range accesses. The first fault latches its cause and address,
//   the monitor drains for DRAIN_CYCLES cycles and then raises a sticky halt
//   that is released only by clear (or reset).
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   stall       core held; monitor returns to / stays in IDLE
//   clear       restart from DONE (ignored elsewhere)
//   bus         observed core signals (exception, pc, ch_valid, ch_addr)
//   running     state is RUN
//   halt        state is DONE (level)
//   halt_pulse  one cycle on entry to DONE
//   cause       0 none, 1 exception, 2 range, 3 timeout
//   fault_ch    channel of a range fault, else 0
//   fault_addr  offending address (range) or pc (exception / timeout)
//   cycle_cnt   cycles spent in RUN, frozen at the trigger
// ---------------------------------------------------------------------------
module run_watchdog #(
  parameter int unsigned          NCH           = 2,
  parameter int unsigned          AW            = 32,
  parameter logic [8*NCH-1:0]     CH_LIMIT_LOG2 = {8'd18, 8'd17},
  parameter int unsigned          TIMEOUT       = 100,
  parameter int unsigned          DRAIN_CYCLES  = 1,
  localparam int unsigned         FCW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 clear,
  run_watchdog_if.slave        bus,
  output logic                 running,
  output logic                 halt,
  output logic                 halt_pulse,
  output logic [1:0]           cause,
  output logic [FCW-1:0]       fault_ch,
  output logic [AW-1:0]        fault_addr,
  output logic [31:0]          cycle_cnt
);

  localparam int unsigned   HW         = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HANG_MAX   = HW'(TIMEOUT);
  localparam int unsigned   DW         = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] pc_q;
  logic [HW-1:0] hang_cnt;
  logic [HW-1:0] hang_next;
  logic [DW-1:0] drain_cnt;

  // Per-channel range check: legal iff every bit at or above the limit is 0.
  // A limit at or beyond the address width can never be exceeded.
  logic [NCH-1:0] ch_oor;

  for (genvar g = 0; g < NCH; g++) begin : g_range
    localparam int unsigned LIM = int'(CH_LIMIT_LOG2[8*g +: 8]);
    if (LIM >= AW) begin : g_never
      assign ch_oor[g] = 1'b0;
    end else begin : g_check
      assign ch_oor[g] = bus.ch_valid[g] && (|bus.ch_addr[AW*g+LIM +: AW-LIM]);
    end
  end

  // Lowest offending channel wins: scan from the top so lower indices overwrite.
  logic           oor_any;
  logic [FCW-1:0] oor_ch;
  logic [AW-1:0]  oor_addr;

  always_comb begin
    oor_any  = |ch_oor;
    oor_ch   = '0;
    oor_addr = '0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (ch_oor[i-1]) begin
        oor_ch   = FCW'(i - 1);
        oor_addr = bus.ch_addr[AW*(i-1) +: AW];
      end
    end
  end

  // Saturating count of consecutive cycles with an unchanged PC.
  always_comb begin
    hang_next = '0;
    if (bus.pc == pc_q) begin
      hang_next = (hang_cnt == HANG_MAX) ? HANG_MAX : hang_cnt + HW'(1);
    end
  end

  // Trigger priority: exception, then range, then hang (uses registered count).
  logic           trig;
  logic [1:0]     trig_cause;
  logic [FCW-1:0] trig_ch;
  logic [AW-1:0]  trig_addr;

  always_comb begin
    trig       = 1'b1;
    trig_cause = 2'd1;
    trig_ch    = '0;
    trig_addr  = bus.pc;
    if (bus.exception) begin
      trig_cause = 2'd1;
      trig_addr  = bus.pc;
    end else if (oor_any) begin
      trig_cause = 2'd2;
      trig_ch    = oor_ch;
      trig_addr  = oor_addr;
    end else if (hang_cnt == HANG_MAX) begin
      trig_cause = 2'd3;
      trig_addr  = pc_q;
    end else begin
      trig = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      running    <= 1'b0;
      halt       <= 1'b0;
      halt_pulse <= 1'b0;
      cause      <= '0;
      fault_ch   <= '0;
      fault_addr <= '0;
      cycle_cnt  <= '0;
      pc_q       <= '0;
      hang_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      halt_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          hang_cnt <= '0;
          if (!stall) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end

        S_RUN: begin
          if (stall) begin
            // The stall cycle is still a RUN cycle, but no trigger is taken.
            state     <= S_IDLE;
            running   <= 1'b0;
            hang_cnt  <= '0;
            cycle_cnt <= cycle_cnt + 32'd1;
            pc_q      <= bus.pc;
          end else if (trig) begin
            // Triggering cycle is not counted: cycle_cnt freezes here.
            running    <= 1'b0;
            cause      <= trig_cause;
            fault_ch   <= trig_ch;
            fault_addr <= trig_addr;
            if (DRAIN_CYCLES == 0) begin
              state      <= S_DONE;
              halt       <= 1'b1;
              halt_pulse <= 1'b1;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_INIT;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            pc_q      <= bus.pc;
            hang_cnt  <= hang_next;
          end
        end

        S_DRAIN: begin
          if (drain_cnt == DRAIN_ONE) begin
            state      <= S_DONE;
            halt       <= 1'b1;
            halt_pulse <= 1'b1;
            drain_cnt  <= '0;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end

        S_DONE: begin
          if (clear) begin
            state      <= S_IDLE;
            halt       <= 1'b0;
            cause      <= '0;
            fault_ch   <= '0;
            fault_addr <= '0;
            cycle_cnt  <= '0;
            hang_cnt   <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
